// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the register file's single write port between the ALU writeback path
// and the memory-load writeback path. One request is accepted per cycle. The
// winning request lands on the registered write/wnum/wdata outputs one cycle
// later.
//
// Arbitration normally favours memory. An ALU request that has been stalled
// for STARVE_LIMIT consecutive cycles wins the next contested cycle. Accepted
// writes to register 0 are acknowledged but never strobed into the register
// file. They are counted in a saturating counter instead.
//
// Handshake (both request ports): a transfer happens on a rising clk edge
// where valid && ready are both high. ready is combinational from the valid
// inputs and the starvation counter, and at most one ready is high per cycle.
// While valid && !ready, the requester holds wnum/wdata stable. Both readys
// are held low while rst is high, so nothing is accepted during reset.
//
// Parameters:
//   STARVE_LIMIT  consecutive stalled ALU cycles before the ALU beats memory
//                 (1..15)
//   CNT_W         width of the zero-write drop counter
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   alu_valid     ALU writeback request
//   alu_wnum      ALU destination register
//   alu_wdata     ALU result
//   alu_ready     ALU request accepted this cycle (combinational)
//   mem_valid     load writeback request
//   mem_wnum      load destination register
//   mem_wdata     load data
//   mem_ready     load request accepted this cycle (combinational)
//   write         register file write strobe (registered)
//   wnum          register file write index (registered)
//   wdata         register file write data (registered)
//   zero_drops    saturating count of accepted writes to register 0
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             alu_valid,
    input  logic [4:0]       alu_wnum,
    input  logic [31:0]      alu_wdata,
    output logic             alu_ready,

    input  logic             mem_valid,
    input  logic [4:0]       mem_wnum,
    input  logic [31:0]      mem_wdata,
    output logic             mem_ready,

    output logic             write,
    output logic [4:0]       wnum,
    output logic [31:0]      wdata,
    output logic [CNT_W-1:0] zero_drops
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Number of consecutive cycles the ALU has been waiting. It saturates at
    // LIMIT, which is all the grant logic needs to know.
    logic [3:0]  starve_cnt;

    logic        grant_alu;
    logic        grant_mem;
    logic        accept;
    logic [4:0]  sel_wnum;
    logic [31:0] sel_wdata;
    logic        sel_is_zero;

    // ------------------------------------------------------------------
    // Grant: memory wins contested cycles unless the ALU has starved long
    // enough. Both grants are forced low during reset so that no transfer
    // is accepted while the output stage is held clear.
    // ------------------------------------------------------------------
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!rst) begin
            if (alu_valid && mem_valid) begin
                if (starve_cnt >= LIMIT) begin
                    grant_alu = 1'b1;
                end else begin
                    grant_mem = 1'b1;
                end
            end else begin
                grant_alu = alu_valid;
                grant_mem = mem_valid;
            end
        end
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    // ------------------------------------------------------------------
    // Winner selection for the output stage.
    // ------------------------------------------------------------------
    always_comb begin
        accept    = 1'b0;
        sel_wnum  = 5'd0;
        sel_wdata = 32'd0;
        if (alu_valid && grant_alu) begin
            accept    = 1'b1;
            sel_wnum  = alu_wnum;
            sel_wdata = alu_wdata;
        end else if (mem_valid && grant_mem) begin
            accept    = 1'b1;
            sel_wnum  = mem_wnum;
            sel_wdata = mem_wdata;
        end
    end

    assign sel_is_zero = (sel_wnum == 5'd0);

    // ------------------------------------------------------------------
    // Starvation counter. After an ALU override it clears, so the next
    // contested cycle goes back to memory. Memory can therefore never be
    // starved.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (!alu_valid || grant_alu) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output stage. write is a single-cycle strobe per accepted non-zero
    // transfer. wnum/wdata follow every accepted transfer, including
    // absorbed register-0 writes, and otherwise hold their last value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write <= 1'b0;
            wnum  <= 5'd0;
            wdata <= 32'd0;
        end else begin
            write <= accept && !sel_is_zero;
            if (accept) begin
                wnum  <= sel_wnum;
                wdata <= sel_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register-0 drop counter. It saturates at all-ones and does not wrap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_drops <= '0;
        end else if (accept && sel_is_zero && (zero_drops != '1)) begin
            zero_drops <= zero_drops + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Stimulus is driven 1 ns after each rising edge. Scenario tasks check the
// combinational ready outputs 3 ns after the edge. A monitor process runs on
// the falling edge. It predicts the grant from its own starvation model and
// compares the ready outputs. It also pushes the expected register file
// write for the next edge into exp_q, and pops and compares the one due now.
// A second instance with CNT_W=2 covers counter saturation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

    localparam int LIMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_wnum  = 5'd0;
    logic [31:0] alu_wdata = 32'd0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_wnum  = 5'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        mem_ready;
    logic        write;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic [7:0]  zero_drops;

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_wnum   (alu_wnum),
        .alu_wdata  (alu_wdata),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_wnum   (mem_wnum),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .write      (write),
        .wnum       (wnum),
        .wdata      (wdata),
        .zero_drops (zero_drops)
    );

    // ---------------- saturation DUT (CNT_W=2) ----------------
    logic        s_alu_valid = 1'b0;
    logic [4:0]  s_alu_wnum  = 5'd0;
    logic [31:0] s_alu_wdata = 32'd0;
    logic        s_alu_ready;
    logic        s_mem_ready;
    logic        s_write;
    logic [4:0]  s_wnum;
    logic [31:0] s_wdata;
    logic [1:0]  s_zero_drops;

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(2)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (s_alu_valid),
        .alu_wnum   (s_alu_wnum),
        .alu_wdata  (s_alu_wdata),
        .alu_ready  (s_alu_ready),
        .mem_valid  (1'b0),
        .mem_wnum   (5'd0),
        .mem_wdata  (32'd0),
        .mem_ready  (s_mem_ready),
        .write      (s_write),
        .wnum       (s_wnum),
        .wdata      (s_wdata),
        .zero_drops (s_zero_drops)
    );

    // ---------------- scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;

    logic [37:0] exp_q[$];          // {write, wnum, wdata}
    logic        mon_en = 1'b0;
    logic [3:0]  m_starve;
    logic [4:0]  m_wnum;
    logic [31:0] m_wdata;
    logic [7:0]  m_zero;

    initial begin
        logic [37:0] e;
        logic        g_alu;
        logic        g_mem;
        logic [4:0]  s_wn;
        logic [31:0] s_wd;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    vectors++;
                    if ({write, wnum, wdata} !== e) begin
                        miscompares++;
                        $display("FAIL wr_port t=%0t got w=%0b n=%0d d=%h exp w=%0b n=%0d d=%h",
                                 $time, write, wnum, wdata, e[37], e[36:32], e[31:0]);
                    end
                end
                if (alu_valid && mem_valid) begin
                    g_alu = (m_starve >= 4'(LIMIT));
                    g_mem = !g_alu;
                end else begin
                    g_alu = alu_valid;
                    g_mem = mem_valid;
                end
                vectors++;
                if ({alu_ready, mem_ready} !== {g_alu, g_mem}) begin
                    miscompares++;
                    $display("FAIL grant t=%0t got alu=%0b mem=%0b exp alu=%0b mem=%0b",
                             $time, alu_ready, mem_ready, g_alu, g_mem);
                end
                vectors++;
                if (zero_drops !== m_zero) begin
                    miscompares++;
                    $display("FAIL zero_cnt t=%0t got %0d exp %0d", $time, zero_drops, m_zero);
                end
                if (g_alu || g_mem) begin
                    s_wn    = g_alu ? alu_wnum  : mem_wnum;
                    s_wd    = g_alu ? alu_wdata : mem_wdata;
                    m_wnum  = s_wn;
                    m_wdata = s_wd;
                    if (s_wn == 5'd0 && m_zero != 8'hFF) m_zero = m_zero + 8'd1;
                    exp_q.push_back({(s_wn != 5'd0), m_wnum, m_wdata});
                end else begin
                    exp_q.push_back({1'b0, m_wnum, m_wdata});
                end
                if (!alu_valid || g_alu)       m_starve = 4'd0;
                else if (m_starve < 4'(LIMIT)) m_starve = m_starve + 4'd1;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic idle_inputs();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // Hold reset and check that every output sits at zero.
        repeat (2) @(posedge clk);
        #3;
        vectors++;
        if ({write, wnum, wdata, zero_drops, alu_ready, mem_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold got w=%0b n=%0d d=%h z=%0d ar=%0b mr=%0b exp all 0",
                     write, wnum, wdata, zero_drops, alu_ready, mem_ready);
        end
        // Release reset, then do a zero write followed by a real write.
        @(posedge clk); #1;
        rst = 1'b0;
        mem_valid = 1'b1; mem_wnum = 5'd0; mem_wdata = 32'h1111_0000;
        @(posedge clk); #1;
        mem_wnum = 5'd9; mem_wdata = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        // Write of reg 9 is now visible and mem_valid is still high.
        vectors++;
        if ({write, wnum, wdata, zero_drops} !== {1'b1, 5'd9, 32'hA5A5_5A5A, 8'd1}) begin
            miscompares++;
            $display("FAIL pre_reset got w=%0b n=%0d d=%h z=%0d exp w=1 n=9 d=a5a55a5a z=1",
                     write, wnum, wdata, zero_drops);
        end
        #2;
        rst = 1'b1;                     // mid-cycle, while a request is pending
        #1;
        vectors++;
        if ({write, wnum, wdata, zero_drops, alu_ready, mem_ready} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got w=%0b n=%0d d=%h z=%0d ar=%0b mr=%0b exp all 0",
                     write, wnum, wdata, zero_drops, alu_ready, mem_ready);
        end
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #2;
            vectors++;
            if (write !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_strobe cycle %0d got write=%0b exp 0", i, write);
            end
        end
        m_starve = 4'd0; m_wnum = 5'd0; m_wdata = 32'd0; m_zero = 8'd0;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_wnum = 5'd5; mem_wdata = 32'hDEAD_BEEF;
        #2;
        vectors++;
        if ({mem_ready, alu_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_ready got mr=%0b ar=%0b exp mr=1 ar=0", mem_ready, alu_ready);
        end
        @(posedge clk); #1;
        idle_inputs();
        #2;
        vectors++;
        if ({write, wnum, wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL single_write got w=%0b n=%0d d=%h exp w=1 n=5 d=deadbeef",
                     write, wnum, wdata);
        end
        @(posedge clk); #3;
        vectors++;
        if (write !== 1'b0) begin
            miscompares++;
            $display("FAIL single_strobe_end got write=%0b exp 0", write);
        end
    endtask

    task automatic test_contention();
        logic prev_alu;
        logic exp_alu;
        prev_alu = 1'b0;
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_wnum = 5'd3; alu_wdata = 32'hA1A1_0003;
        mem_valid = 1'b1; mem_wnum = 5'd7; mem_wdata = 32'hB2B2_0007;
        for (int i = 0; i < 10; i++) begin
            #2;
            exp_alu = ((i % 5) == 4);
            vectors++;
            if ({alu_ready, mem_ready} !== {exp_alu, !exp_alu}) begin
                miscompares++;
                $display("FAIL contend_grant cycle %0d got ar=%0b mr=%0b exp ar=%0b mr=%0b",
                         i, alu_ready, mem_ready, exp_alu, !exp_alu);
            end
            if (i > 0) begin
                vectors++;
                if ({write, wnum} !== {1'b1, (prev_alu ? 5'd3 : 5'd7)}) begin
                    miscompares++;
                    $display("FAIL contend_write cycle %0d got w=%0b n=%0d exp w=1 n=%0d",
                             i, write, wnum, prev_alu ? 3 : 7);
                end
            end
            prev_alu = exp_alu;
            @(posedge clk); #1;
        end
        idle_inputs();
        #2;
        vectors++;
        if ({write, wnum, wdata} !== {1'b1, 5'd3, 32'hA1A1_0003}) begin
            miscompares++;
            $display("FAIL contend_last got w=%0b n=%0d d=%h exp w=1 n=3 d=a1a10003",
                     write, wnum, wdata);
        end
        @(posedge clk);
    endtask

    task automatic test_zero_write();
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_wnum = 5'd0; alu_wdata = 32'h0000_1234;
        #2;
        vectors++;
        if ({alu_ready, zero_drops} !== {1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL zero_accept got ar=%0b z=%0d exp ar=1 z=0", alu_ready, zero_drops);
        end
        @(posedge clk); #1;
        idle_inputs();
        #2;
        vectors++;
        if ({write, wnum, wdata, zero_drops} !== {1'b0, 5'd0, 32'h0000_1234, 8'd1}) begin
            miscompares++;
            $display("FAIL zero_absorb got w=%0b n=%0d d=%h z=%0d exp w=0 n=0 d=00001234 z=1",
                     write, wnum, wdata, zero_drops);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_starve_clear();
        logic [8:0] alu_v_pat;
        logic [8:0] alu_g_pat;
        alu_v_pat = 9'b1_1111_0111;     // bit i = alu_valid in cycle i
        alu_g_pat = 9'b1_0000_0000;     // bit i = expected ALU grant
        @(posedge clk); #1;
        alu_wnum = 5'd11; alu_wdata = 32'hC0DE_000B;
        mem_valid = 1'b1; mem_wnum = 5'd12; mem_wdata = 32'hC0DE_000C;
        for (int i = 0; i < 9; i++) begin
            alu_valid = alu_v_pat[i];
            #2;
            vectors++;
            if ({alu_ready, mem_ready} !== {alu_g_pat[i], !alu_g_pat[i]}) begin
                miscompares++;
                $display("FAIL starve_clear cycle %0d got ar=%0b mr=%0b exp ar=%0b mr=%0b",
                         i, alu_ready, mem_ready, alu_g_pat[i], !alu_g_pat[i]);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk);
    endtask

    task automatic test_saturation();
        logic [1:0] exp_z[5];
        exp_z = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        @(posedge clk); #1;
        s_alu_valid = 1'b1; s_alu_wnum = 5'd0; s_alu_wdata = 32'h5A5A_0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            vectors++;
            if ({s_zero_drops, s_write} !== {exp_z[i], 1'b0}) begin
                miscompares++;
                $display("FAIL sat_count write %0d got z=%0d w=%0b exp z=%0d w=0",
                         i, s_zero_drops, s_write, exp_z[i]);
            end
        end
        s_alu_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        logic a_took;
        logic m_took;
        a_took = 1'b1;
        m_took = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 80; c++) begin
            // A new request is only issued once the previous one was taken.
            if (!alu_valid || a_took) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_wnum  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                alu_wdata = $urandom;
            end
            if (!mem_valid || m_took) begin
                mem_valid = ($urandom_range(0, 3) != 0);
                mem_wnum  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                mem_wdata = $urandom;
            end
            #2;
            a_took = alu_valid && alu_ready;
            m_took = mem_valid && mem_ready;
            @(posedge clk); #1;
        end
        idle_inputs();
        repeat (3) @(posedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_contention();
        test_zero_write();
        test_starve_clear();
        test_saturation();
        test_back_to_back();
        @(negedge clk);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: the ALU result path and the memory-load path.
- Accepts one request per cycle using valid/ready handshakes.
- Drives the register file's write, wnum and wdata from registered outputs.
- Arbitration is fixed priority to memory, with an ALU anti-starvation override; writes to register 0 are silently absorbed and counted.

Parameters:
- STARVE_LIMIT, 4: consecutive stalled ALU cycles after which the ALU beats memory (range 1..15).
- CNT_W, 8: width of the dropped-zero-write counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- alu_valid  input  1  ALU writeback request.
- alu_wnum  input  5  ALU destination register.
- alu_wdata  input  32  ALU result.
- alu_ready  output  1  ALU request accepted this cycle (combinational).
- mem_valid  input  1  load writeback request.
- mem_wnum  input  5  load destination register.
- mem_wdata  input  32  load data.
- mem_ready  output  1  load request accepted this cycle (combinational).
- write  output  1  register file write strobe (registered).
- wnum  output  5  register file write index (registered).
- wdata  output  32  register file write data (registered).
- zero_drops  output  CNT_W  saturating count of accepted writes to register 0.

Behaviour:
- Reset (async, immediate):
  - write=0, wnum=0, wdata=0, zero_drops=0, starvation counter=0.
  - alu_ready=0 and mem_ready=0 while rst is high.
  - A transfer accepted in the cycle rst asserts is discarded; no write strobe follows.
- Handshake: transfer occurs on a rising edge where valid && ready. Requesters hold wnum/wdata stable while valid && !ready.
- Grant (combinational, at most one ready high per cycle):
  - mem_valid only -> mem_ready=1.
  - alu_valid only -> alu_ready=1.
  - Both valid, starve_cnt < STARVE_LIMIT -> mem_ready=1, alu_ready=0.
  - Both valid, starve_cnt >= STARVE_LIMIT -> alu_ready=1, mem_ready=0.
  - Neither valid -> both ready low.
- Starvation counter (width 4):
  - Cleared when alu_valid is low or the ALU is accepted.
  - Increments when alu_valid && !alu_ready; saturates at STARVE_LIMIT.
- Output stage (one-cycle latency):
  - On the edge following acceptance: wnum/wdata <= winner's wnum/wdata; write <= 1 if winner's wnum != 0, else 0.
  - With no acceptance: write <= 0; wnum/wdata hold their last value.
  - write is never high for two cycles unless two transfers are accepted on consecutive cycles. Back-to-back throughput is one write per cycle.
- Zero absorption: an accepted transfer with wnum==0 is still acknowledged (ready=1). zero_drops increments by 1 and saturates at 2^CNT_W-1, no wrap.
- Memory starvation is impossible: after an ALU override the counter clears, so the next contested cycle goes to memory.
- Same destination from both sources in one cycle: only the winner is written; the loser retries later and its value lands last.

Test Plan:
- Reset: assert rst mid-cycle while mem_valid=1 -> write, wnum, wdata and zero_drops drop to 0 immediately; no strobe appears after rst releases until a new accept.
- Single source: mem_valid=1, mem_wnum=5, mem_wdata=0xDEADBEEF for one cycle -> mem_ready=1 that cycle; next cycle write=1, wnum=5, wdata=0xDEADBEEF; following cycle write=0.
- Contention with STARVE_LIMIT=4: both valid continuously, alu_wnum=3, mem_wnum=7 -> grants are mem×4, alu×1, mem×4, alu×1. Write strobes appear one cycle after each grant with the matching wnum.
- Zero write: alu_valid=1, alu_wnum=0, alu_wdata=0x1234 -> alu_ready=1; next cycle write=0 and zero_drops increments 0->1.
- Counter saturation with CNT_W=2: five zero writes -> zero_drops reads 1, 2, 3, 3, 3.
- Starvation-counter clear: alu_valid drops for one cycle after three stalls, then both valid again -> memory wins the next four contested cycles before the ALU is granted.
